// File: rtl/sm83_mem_responder.sv
// Memory-side responder for the SM83 bus: latches a CPU access, serves WRAM/echo,
// HRAM and IE after WAIT_STATES wait cycles, and completes with a one-cycle ack.
module sm83_mem_responder #(
    parameter int ADR_WIDTH   = 16,
    parameter int WRAM_AW     = 13,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cyc,
    input  logic                 we,
    input  logic [ADR_WIDTH-1:0] adr,
    input  logic [7:0]           wdata,
    output logic                 ack,
    output logic [7:0]           rdata,
    output logic                 miss,
    output logic                 busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    logic [1:0]           state;
    logic [3:0]           cnt;
    logic [ADR_WIDTH-1:0] adr_q;
    logic                 we_q;
    logic [7:0]           wdata_q;
    logic [7:0]           ie_q;

    logic [7:0] wram [2**WRAM_AW];
    logic [7:0] hram [128];

    logic       hit_wram;
    logic       hit_hram;
    logic       hit_ie;
    logic       mapped;
    logic [7:0] rd_data;
    logic       commit;

    // 0xC000-0xDFFF plus its echo 0xE000-0xFDFF share one WRAM index.
    always_comb begin
        hit_wram = (adr_q[15:13] == 3'b110) ||
                   ((adr_q[15:13] == 3'b111) && (adr_q[12:9] != 4'hF));
        hit_hram = (adr_q[15:7] == 9'h1FF) && (adr_q[6:0] != 7'h7F);
        hit_ie   = (adr_q == 16'hFFFF);
        mapped   = hit_wram || hit_hram || hit_ie;
    end

    always_comb begin
        rd_data = 8'hFF;
        if (hit_wram) begin
            rd_data = wram[adr_q[WRAM_AW-1:0]];
        end else if (hit_hram) begin
            rd_data = hram[adr_q[6:0]];
        end else if (hit_ie) begin
            rd_data = ie_q;
        end
    end

    always_comb begin
        ack   = (state == ACK);
        busy  = (state != IDLE);
        rdata = ack ? rd_data : 8'hFF;
        miss  = ack && !mapped;
    end

    // A write lands only at the edge closing ACK, and only if the CPU still holds cyc.
    assign commit = !reset && (state == ACK) && cyc && we_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ie_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cyc) begin
                        adr_q   <= adr;
                        we_q    <= we;
                        wdata_q <= wdata;
                        cnt     <= WAIT_INIT;
                        state   <= (WAIT_INIT == 4'd0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!cyc) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == 4'd1) begin
                        state <= ACK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    if (commit && hit_ie) begin
                        ie_q <= wdata_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (commit && hit_wram) begin
            wram[adr_q[WRAM_AW-1:0]] <= wdata_q;
        end
        if (commit && hit_hram) begin
            hram[adr_q[6:0]] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_sm83_mem_responder.sv
// Bench for sm83_mem_responder: three instances with different wait-state counts,
// directed scenarios plus random traffic checked against a flat 64 KiB byte model.
module tb_sm83_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_s [3];
    logic        cyc_s   [3];
    logic        we_s    [3];
    logic [15:0] adr_s   [3];
    logic [7:0]  wdata_s [3];
    logic        ack_s   [3];
    logic [7:0]  rdata_s [3];
    logic        miss_s  [3];
    logic        busy_s  [3];

    int ws [3] = '{0, 3, 2};

    sm83_mem_responder #(.ADR_WIDTH(16), .WRAM_AW(13), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset_s[0]), .cyc(cyc_s[0]), .we(we_s[0]), .adr(adr_s[0]),
        .wdata(wdata_s[0]), .ack(ack_s[0]), .rdata(rdata_s[0]), .miss(miss_s[0]), .busy(busy_s[0]));
    sm83_mem_responder #(.ADR_WIDTH(16), .WRAM_AW(13), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(reset_s[1]), .cyc(cyc_s[1]), .we(we_s[1]), .adr(adr_s[1]),
        .wdata(wdata_s[1]), .ack(ack_s[1]), .rdata(rdata_s[1]), .miss(miss_s[1]), .busy(busy_s[1]));
    sm83_mem_responder #(.ADR_WIDTH(16), .WRAM_AW(13), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset_s[2]), .cyc(cyc_s[2]), .we(we_s[2]), .adr(adr_s[2]),
        .wdata(wdata_s[2]), .ack(ack_s[2]), .rdata(rdata_s[2]), .miss(miss_s[2]), .busy(busy_s[2]));

    // Reference memory indexed by canonical CPU address (echo folded onto WRAM).
    logic [7:0] ref_mem [3][65536];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mapped(input logic [15:0] a);
        return (a >= 16'hC000 && a <= 16'hFDFF) || (a >= 16'hFF80);
    endfunction

    function automatic logic [15:0] canon(input logic [15:0] a);
        if (a >= 16'hE000 && a <= 16'hFDFF) return a - 16'h2000;
        return a;
    endfunction

    task automatic begin_acc(input int i, input bit w, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        chk("idle_busy", busy_s[i], 0);
        cyc_s[i]   = 1'b1;
        we_s[i]    = w;
        adr_s[i]   = a;
        wdata_s[i] = d;
        @(posedge clk);
        #1;
        adr_s[i]   = 16'($urandom);
        wdata_s[i] = 8'($urandom);
        we_s[i]    = 1'($urandom);
    endtask

    task automatic wait_ack(input int i, output bit got, output int k);
        got = 1'b0;
        k   = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (ack_s[i] === 1'b1) got = 1'b1;
            else chk("wait_busy", busy_s[i], 1);
        end
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    task automatic finish_acc(input int i, input bit w, input logic [15:0] a, input logic [7:0] d,
                              input bit got);
        @(posedge clk);
        #1;
        cyc_s[i] = 1'b0;
        if (got && w && is_mapped(a)) ref_mem[i][canon(a)] = d;
        @(negedge clk);
        chk("post_ack", ack_s[i], 0);
        chk("post_rdata", rdata_s[i], 8'hFF);
        chk("post_miss", miss_s[i], 0);
    endtask

    task automatic access(input int i, input bit w, input logic [15:0] a, input logic [7:0] d);
        bit got;
        int k;
        begin_acc(i, w, a, d);
        wait_ack(i, got, k);
        if (got) begin
            chk("latency", k, ws[i] + 1);
            chk("ack_busy", busy_s[i], 1);
            chk("miss", miss_s[i], is_mapped(a) ? 0 : 1);
            if (!w) chk("rdata", rdata_s[i], is_mapped(a) ? ref_mem[i][canon(a)] : 8'hFF);
        end
        finish_acc(i, w, a, d, got);
    endtask

    initial begin
        bit got;
        int k;
        for (int i = 0; i < 3; i++) begin
            reset_s[i] = 1'b1; cyc_s[i] = 1'b0; we_s[i] = 1'b0; adr_s[i] = '0; wdata_s[i] = '0;
            ref_mem[i][16'hFFFF] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) reset_s[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ack", ack_s[i], 0);
            chk("rst_rdata", rdata_s[i], 8'hFF);
            chk("rst_miss", miss_s[i], 0);
            chk("rst_busy", busy_s[i], 0);
        end

        access(0, 1, 16'hC123, 8'hA5);
        access(0, 0, 16'hE123, 8'h00);

        access(1, 1, 16'hFF80, 8'h3C);
        access(1, 0, 16'hFF80, 8'h00);

        access(0, 1, 16'hFFFE, 8'h11);
        access(0, 1, 16'hFFFF, 8'h1F);
        access(0, 0, 16'hFFFE, 8'h00);
        access(0, 0, 16'hFFFF, 8'h00);
        access(0, 0, 16'hFF7F, 8'h00);

        access(0, 1, 16'h8000, 8'h00);
        access(0, 0, 16'h8000, 8'h00);
        access(0, 0, 16'hC123, 8'h00);
        access(0, 0, 16'hFFFE, 8'h00);

        // Abort during WAIT: no ack, no write.
        access(2, 1, 16'hC000, 8'h42);
        begin_acc(2, 1, 16'hC000, 8'h77);
        @(negedge clk);
        chk("abort_wait_ack", ack_s[2], 0);
        chk("abort_wait_busy", busy_s[2], 1);
        cyc_s[2] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle_ack", ack_s[2], 0);
            chk("abort_idle_busy", busy_s[2], 0);
        end
        access(2, 0, 16'hC000, 8'h00);

        // Abort while ack is already high: write suppressed.
        begin_acc(0, 1, 16'hC123, 8'h00);
        @(negedge clk);
        chk("abort_ack_ack", ack_s[0], 1);
        cyc_s[0] = 1'b0;
        @(negedge clk);
        chk("abort_ack_after", ack_s[0], 0);
        access(0, 0, 16'hC123, 8'h00);

        // Reset during ACK of a write: write dropped, IE cleared.
        access(0, 1, 16'hC010, 8'h5A);
        begin_acc(0, 1, 16'hC010, 8'h99);
        wait_ack(0, got, k);
        reset_s[0] = 1'b1;
        @(posedge clk);
        #1;
        reset_s[0] = 1'b0;
        cyc_s[0]   = 1'b0;
        ref_mem[0][16'hFFFF] = 8'h00;
        @(negedge clk);
        chk("rst_mid_ack", ack_s[0], 0);
        chk("rst_mid_busy", busy_s[0], 0);
        chk("rst_mid_rdata", rdata_s[0], 8'hFF);
        access(0, 0, 16'hFFFF, 8'h00);
        access(0, 0, 16'hC010, 8'h00);

        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 40; n++) begin
                logic [15:0] a;
                bit          w;
                int unsigned r;
                r = $urandom_range(0, 9);
                if (r < 5)      a = 16'hC000 + 16'($urandom_range(0, 16'h3DFF));
                else if (r < 7) a = 16'hFF80 + 16'($urandom_range(0, 127));
                else if (r < 9) a = 16'($urandom_range(0, 16'hBFFF));
                else            a = 16'hFE00 + 16'($urandom_range(0, 16'h017F));
                w = 1'($urandom);
                if (!w && is_mapped(a) && $isunknown(ref_mem[i][canon(a)])) w = 1'b1;
                access(i, w, a, 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm83_mem_responder.md
Name: sm83_mem_responder

Overview:
- Memory-side responder for the SM83 CPU address/data bus.
- Latches the address, write strobe and write data that the CPU address unit presents, then decodes the region.
- Serves WRAM (with echo mirror), HRAM and the IE register from internal storage, after a programmable number of wait states.
- Completes each access with a one-cycle ack. Unmapped regions are answered with open-bus data and a miss flag.

Parameters:
- ADR_WIDTH, 16, CPU address width. Must be 16.
- WRAM_AW, 13, WRAM address width (8 KiB).
- WAIT_STATES, 0, extra cycles inserted between capture and ack (0..15).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  reset, synchronous, active-high.
- cyc  in  1  CPU access request; held high until ack.
- we  in  1  1 = write, 0 = read; valid while cyc.
- adr  in  ADR_WIDTH  CPU byte address; valid while cyc.
- wdata  in  8  write data; valid while cyc.
- ack  out  1  one-cycle completion pulse.
- rdata  out  8  read data; valid only in the ack cycle.
- miss  out  1  access hit an unmapped region; valid in the ack cycle.
- busy  out  1  responder is not in IDLE.

Behaviour:
- Reset values: ack=0, rdata=8'hFF, miss=0, busy=0, state=IDLE, wait counter=0, IE register=8'h00. WRAM and HRAM contents are not reset.
- Region decode on the latched address (adr_q):
  - 0xC000–0xDFFF: WRAM, index adr_q[12:0].
  - 0xE000–0xFDFF: echo; same WRAM index adr_q[12:0] (0xE123 aliases 0xC123).
  - 0xFF80–0xFFFE: HRAM, 127 bytes, index adr_q[6:0].
  - 0xFFFF: IE register, 8 bits, full byte readable and writable.
  - Everything else is unmapped: read returns 8'hFF, write is discarded, miss=1 at ack.
- States:
  - IDLE: when cyc=1, capture adr/we/wdata into adr_q/we_q/wdata_q and load counter with WAIT_STATES. Go to ACK if WAIT_STATES=0, else go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, go to ACK on the next edge.
  - ACK: ack=1; rdata and miss driven for this cycle only; write committed at the edge that ends ACK. Then return to IDLE.
- Latency:
  - cyc sampled high at edge N gives ack high during cycle N+1+WAIT_STATES.
  - A read returns the storage contents as they were before any write committed at the same edge.
- Back-to-back: if cyc is still high in the IDLE cycle after ACK, a new access is captured. The CPU drops cyc in the cycle after it sees ack unless it wants a new access.
- Abort: if cyc falls while in WAIT or ACK, return to IDLE on the next edge.
  - No write is committed, ack stays 0.
  - The abort takes effect even if ack is already high in that cycle; the write is suppressed.
- Inputs are ignored after capture. Changes to adr/we/wdata during WAIT have no effect.
- Outside the ack cycle: rdata=8'hFF, miss=0.
- busy=1 in WAIT and ACK.
- Reset mid-operation: go to IDLE, ack=0, pending write dropped, IE cleared.
- Reset has priority over everything.

Test Plan:
- WAIT_STATES=0: write 8'hA5 to 0xC123, then read 0xE123 -> ack one cycle after each capture; rdata=8'hA5, miss=0.
- WAIT_STATES=3: read 0xFF80 after writing 8'h3C -> ack exactly 4 cycles after capture, rdata=8'h3C. busy=1 for those 4 cycles.
- HRAM/IE boundary:
  - Write 8'h11 to 0xFFFE and 8'h1F to 0xFFFF.
  - Read both back -> 8'h11 and 8'h1F.
  - Read 0xFF7F -> rdata=8'hFF, miss=1.
- Unmapped write 0x8000=8'h00, then read 0x8000 -> rdata=8'hFF, miss=1; WRAM/HRAM unchanged.
- Abort: WAIT_STATES=2, write 8'h77 to 0xC000 with cyc dropped during WAIT -> no ack; a later read of 0xC000 returns the old value.
- Reset mid-write in ACK with IE previously 8'h1F -> no ack after reset; IE reads 8'h00; target WRAM byte unchanged.
